// File: rtl/signal_async_requester.sv
// signal_async_requester: accepts one command at a time and forwards its operand
// to a fixed-latency downstream incrementer with a one-cycle request strobe. The
// response is captured LATENCY cycles later and checked against operand+1. The
// result is then held until the consumer accepts it.
module signal_async_requester #(
  parameter int LATENCY = 2,   // legal range 1..15
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             request,
  output logic [WIDTH-1:0] input_data,
  input  logic [WIDTH-1:0] final_resp,
  input  logic             final_resp_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             err_sticky,
  output logic [15:0]      txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] LOAD_CNT = 4'(LATENCY);

  state_e           state_q,      state_d;
  logic             request_q,    request_d;
  logic [WIDTH-1:0] input_data_q, input_data_d;
  logic [3:0]       wait_cnt_q,   wait_cnt_d;
  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_err_q,    out_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [15:0]      txn_count_q,  txn_count_d;
  logic             resp_bad;

  // Response check; only consumed in the capture cycle, so X on the downstream
  // inputs at any other time never reaches a flop.
  always_comb begin
    resp_bad = !final_resp_valid || (final_resp != input_data_q + WIDTH'(1));
  end

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latch).
    state_d      = state_q;
    request_d    = 1'b0;
    input_data_d = input_data_q;
    wait_cnt_d   = wait_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;
    txn_count_d  = txn_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          input_data_d = cmd_data;
          request_d    = 1'b1;         // strobe lands in the ISSUE cycle
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = LOAD_CNT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          out_data_d   = final_resp;
          out_err_d    = resp_bad;
          err_sticky_d = err_sticky_q | resp_bad;
          out_valid_d  = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; synchronous active-high reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      request_q    <= 1'b0;
      input_data_q <= '0;
      wait_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      txn_count_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      request_q    <= request_d;
      input_data_q <= input_data_d;
      wait_cnt_q   <= wait_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      txn_count_q  <= txn_count_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE) && !reset;
  assign request    = request_q;
  assign input_data = input_data_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
  assign txn_count  = txn_count_q;

endmodule
